// File: rtl/modulator_scheduler_if.sv
// modulator_scheduler_if: config handshake bundle for the carrier scheduler
//   cfg_valid  - new config offered (master -> slave)
//   cfg_ready  - config can be accepted (slave -> master)
//   cfg_period - carrier half-period P (peak value)
//   cfg_phase  - phase step between successive carriers, in sawtooth counts
interface modulator_scheduler_if #(parameter int CNT_W = 10);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_phase;
  modport master(output cfg_valid, cfg_period, cfg_phase, input cfg_ready);
  modport slave(input cfg_valid, cfg_period, cfg_phase, output cfg_ready);
endinterface

// File: rtl/modulator_scheduler.sv
// modulator_scheduler: phase-shifted triangle carriers, soft start and fault shutdown for NBR H-bridges
//   clk, rst  - clock, asynchronous active-low reset
//   cfg       - period/phase config handshake (slave side), applied at the carrier valley
//   en, fault - run request and external fault, both level-sensitive
//   carrier   - registered triangle value per bridge, bridge k at [k*CNT_W +: CNT_W]
//   bridge_en - per-bridge gate enable, set one by one at each carrier's valley
//   sync/peak - pulses aligned with carrier[0] at 0 and at P
//   state_o   - 00 IDLE, 01 RAMP, 10 RUN, 11 FAULT
module modulator_scheduler #(
  parameter int CNT_W = 10,
  parameter int NBR = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  modulator_scheduler_if.slave   cfg,
  input  logic                   en,
  input  logic                   fault,
  output logic [NBR*CNT_W-1:0]   carrier,
  output logic [NBR-1:0]         bridge_en,
  output logic                   sync,
  output logic                   peak,
  output logic [1:0]             state_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RAMP = 2'b01, RUN = 2'b10, FAULT = 2'b11} state_t;
  localparam int SW = CNT_W + 1;
  localparam int IW = CNT_W + 1 + $clog2(NBR);
  state_t state, nxt;
  logic [CNT_W-1:0] p_a, ph_a, sh_p, sh_ph;
  logic sh_full;
  logic [SW-1:0] s, s_nxt, p2;
  logic run, run_nxt, both, wrap;
  logic [IW-1:0] idx [NBR];
  logic [CNT_W-1:0] tv [NBR];
  logic [NBR*CNT_W-1:0] car_nxt;
  logic [NBR-1:0] zero, be_nxt;
  assign p2 = {p_a, 1'b0};
  assign run = state == RAMP || state == RUN;
  assign run_nxt = nxt == RAMP || nxt == RUN;
  // carriers only advance when running both before and after the edge, so a stop wins over a wrap
  assign both = run && run_nxt;
  assign wrap = both && s == p2 - SW'(1);
  assign s_nxt = both ? (wrap ? '0 : s + SW'(1)) : '0;
  assign cfg.cfg_ready = !sh_full;
  assign state_o = state;
  always_comb begin
    nxt = state;
    if (fault) nxt = FAULT;
    else if (state == IDLE) nxt = (en && p_a != '0) ? RAMP : IDLE;
    else if (!en) nxt = IDLE;
    else if (state == RAMP && &bridge_en) nxt = RUN;
  end
  // index is s + k*PH folded back into one period; each fold removes at most one 2P
  always_comb begin
    car_nxt = '0;
    zero = '0;
    for (int k = 0; k < NBR; k++) begin
      idx[k] = IW'(s) + IW'(k) * IW'(ph_a);
      for (int j = 1; j < NBR; j++) idx[k] = idx[k] >= IW'(p2) ? idx[k] - IW'(p2) : idx[k];
      tv[k] = idx[k] <= IW'(p_a) ? idx[k][CNT_W-1:0] : CNT_W'(IW'(p2) - idx[k]);
      zero[k] = tv[k] == '0;
      car_nxt[k*CNT_W +: CNT_W] = both ? tv[k] : '0;
    end
  end
  // enables latch at the edge that presents each carrier's valley, so they rise with carrier_k = 0
  assign be_nxt = !run_nxt ? '0 : state == RAMP ? bridge_en | zero : bridge_en;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s <= '0;
      p_a <= '0;
      ph_a <= '0;
      sh_p <= '0;
      sh_ph <= '0;
      sh_full <= 1'b0;
      carrier <= '0;
      bridge_en <= '0;
      sync <= 1'b0;
      peak <= 1'b0;
    end else begin
      state <= nxt;
      s <= s_nxt;
      carrier <= car_nxt;
      bridge_en <= be_nxt;
      sync <= both && s == '0;
      peak <= both && s == SW'(p_a);
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        sh_p <= cfg.cfg_period;
        sh_ph <= cfg.cfg_phase;
        sh_full <= 1'b1;
      end else if (sh_full && (!run || wrap)) begin
        p_a <= sh_p;
        ph_a <= sh_ph;
        sh_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_modulator_scheduler.sv
// tb_modulator_scheduler: randomized scoreboard bench for modulator_scheduler against a period/phase reference model
module tb_modulator_scheduler;
  localparam int CNT_W = 10;
  localparam int NBR = 3;
  typedef struct packed {
    logic [1:0] st;
    logic [NBR*CNT_W-1:0] car;
    logic [NBR-1:0] be;
    logic sy;
    logic pk;
    logic rdy;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic fault = 1'b0;
  logic [NBR*CNT_W-1:0] carrier;
  logic [NBR-1:0] bridge_en;
  logic sync, peak;
  logic [1:0] state_o;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  exp_t got;
  modulator_scheduler_if #(.CNT_W(CNT_W)) cif();
  modulator_scheduler #(.CNT_W(CNT_W), .NBR(NBR)) dut (
    .clk(clk), .rst(rst), .cfg(cif), .en(en), .fault(fault),
    .carrier(carrier), .bridge_en(bridge_en), .sync(sync), .peak(peak), .state_o(state_o)
  );
  always #5 clk = ~clk;
  // reference model: operating mode, active/shadow config, position within the current carrier period
  int m_st, m_pos, m_p, m_ph, m_sp, m_sph;
  bit m_full;
  bit [NBR-1:0] m_be;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic int tri_of(int k, int pos, int p, int ph);
    int i;
    i = (pos + k * ph) % (2 * p);
    return i <= p ? i : 2 * p - i;
  endfunction
  task automatic model_reset();
    m_st = 0; m_pos = 0; m_p = 0; m_ph = 0; m_sp = 0; m_sph = 0; m_full = 0; m_be = '0;
  endtask
  task automatic model_step(input bit e_i, input bit f_i, input bit cv, input int cp, input int cph, output exp_t e);
    int nst;
    bit running, nrun, go, at_end;
    bit [NBR-1:0] nbe;
    running = m_st == 1 || m_st == 2;
    if (f_i) nst = 3;
    else if (m_st == 0) nst = (e_i && m_p != 0) ? 1 : 0;
    else if (!e_i) nst = 0;
    else if (m_st == 1 && m_be == '1) nst = 2;
    else nst = m_st;
    nrun = nst == 1 || nst == 2;
    go = running && nrun;
    at_end = go && m_pos == 2 * m_p - 1;
    e = '0;
    nbe = nrun ? m_be : '0;
    for (int k = 0; k < NBR; k++) begin
      int t;
      t = go ? tri_of(k, m_pos, m_p, m_ph) : 0;
      e.car[k*CNT_W +: CNT_W] = CNT_W'(t);
      if (go && m_st == 1 && t == 0) nbe[k] = 1'b1;
    end
    e.sy = go && m_pos == 0;
    e.pk = go && m_pos == m_p;
    m_pos = go ? (m_pos + 1) % (2 * m_p) : 0;
    if (cv && !m_full) begin
      m_sp = cp; m_sph = cph; m_full = 1;
    end else if (m_full && (!running || at_end)) begin
      m_p = m_sp; m_ph = m_sph; m_full = 0;
    end
    m_st = nst;
    m_be = nbe;
    e.st = 2'(nst);
    e.be = nbe;
    e.rdy = !m_full;
  endtask
  task automatic step(input bit e_i, input bit f_i, input bit cv, input int cp, input int cph);
    exp_t e;
    en = e_i;
    fault = f_i;
    cif.cfg_valid = cv;
    cif.cfg_period = CNT_W'(cp);
    cif.cfg_phase = CNT_W'(cph);
    model_step(e_i, f_i, cv, cp, cph, e);
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_carrier"}, 64'(carrier), 64'd0);
    chk({tag, "_bridge_en"}, 64'(bridge_en), 64'd0);
    chk({tag, "_sync_peak"}, {62'd0, sync, peak}, 64'd0);
    chk({tag, "_state"}, 64'(state_o), 64'd0);
    chk({tag, "_cfg_ready"}, 64'(cif.cfg_ready), 64'd1);
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    #1 rst = 1'b1;
    model_reset();
  endtask
  task automatic run_for(input int n, input bit e_i);
    for (int i = 0; i < n; i++) step(e_i, 1'b0, 1'b0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      got = q.pop_front();
      chk("state", 64'(state_o), 64'(got.st));
      chk("carrier", 64'(carrier), 64'(got.car));
      chk("bridge_en", 64'(bridge_en), 64'(got.be));
      chk("sync", 64'(sync), 64'(got.sy));
      chk("peak", 64'(peak), 64'(got.pk));
      chk("cfg_ready", 64'(cif.cfg_ready), 64'(got.rdy));
    end
  end
  initial begin
    bit e_r;
    cif.cfg_valid = 1'b0;
    cif.cfg_period = '0;
    cif.cfg_phase = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset");
    #1 rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 6, 4);
    run_for(2, 1'b0);
    run_for(40, 1'b1);
    step(1'b1, 1'b0, 1'b1, 9, 6);
    run_for(50, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    run_for(5, 1'b1);
    run_for(3, 1'b0);
    run_for(30, 1'b1);
    reset_pulse();
    run_for(5, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5, 0);
    run_for(2, 1'b0);
    run_for(30, 1'b1);
    e_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int cp, cph;
      if ($urandom_range(0, 99) < 3) e_r = !e_r;
      cp = $urandom_range(3, 12);
      cph = $urandom_range(0, 2 * cp - 1);
      step(e_r, $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, cp, cph);
      if ($urandom_range(0, 599) == 0) reset_pulse();
    end
    run_for(1, 1'b0);
    @(negedge clk);
    #1 chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
